// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - multi-lane IF->ID pipeline register with one-entry skid buffer and perf counters
module if_id_pipe_reg #(
  parameter int                 LANES        = 1,
  parameter int                 PC_W         = 32,
  parameter int                 INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = '0,
  parameter int                 CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_en,
  input  logic                     id_shouldStall,
  input  logic                     id_shouldJumpOrBranch,
  input  logic                     ex_shouldJumpOrBranch,
  input  logic [LANES-1:0]         if_valid,
  input  logic [LANES*PC_W-1:0]    if_pc_4,
  input  logic [LANES*INSTR_W-1:0] if_instruction,
  output logic                     if_ready,
  output logic [LANES-1:0]         id_valid,
  output logic [LANES*PC_W-1:0]    id_pc_4,
  output logic [LANES*INSTR_W-1:0] id_instruction,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_count
);

  logic                     skid_full;
  logic [LANES-1:0]         skid_valid;
  logic [LANES*PC_W-1:0]    skid_pc_4;
  logic [LANES*INSTR_W-1:0] skid_instruction;

  logic                     flush;
  logic                     stall;
  logic                     accept;
  logic [LANES*INSTR_W-1:0] in_instr_masked;
  logic [LANES*INSTR_W-1:0] skid_instr_masked;

  assign flush    = id_shouldJumpOrBranch | ex_shouldJumpOrBranch;
  assign stall    = id_shouldStall;
  assign if_ready = cpu_en & ~skid_full;
  assign accept   = (|if_valid) & if_ready;

  // Invalid lanes carry the bubble encoding into ID; the skid keeps raw data and masks on the way out.
  always_comb begin
    in_instr_masked   = '0;
    skid_instr_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      in_instr_masked[i*INSTR_W +: INSTR_W]   = if_valid[i]   ? if_instruction[i*INSTR_W +: INSTR_W]   : BUBBLE_INSTR;
      skid_instr_masked[i*INSTR_W +: INSTR_W] = skid_valid[i] ? skid_instruction[i*INSTR_W +: INSTR_W] : BUBBLE_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid         <= '0;
      id_pc_4          <= '0;
      id_instruction   <= {LANES{BUBBLE_INSTR}};
      skid_full        <= 1'b0;
      skid_valid       <= '0;
      skid_pc_4        <= '0;
      skid_instruction <= '0;
      stall_cycles     <= '0;
      flush_count      <= '0;
    end else if (cpu_en) begin
      if (flush) begin
        // Wrong-path work in ID, skid and on the IF bus is all dropped; PC+4 is left as-is.
        id_valid       <= '0;
        id_instruction <= {LANES{BUBBLE_INSTR}};
        skid_full      <= 1'b0;
        if (flush_count != {CNT_W{1'b1}})
          flush_count <= flush_count + CNT_W'(1);
      end else if (stall) begin
        if (accept) begin
          skid_full        <= 1'b1;
          skid_valid       <= if_valid;
          skid_pc_4        <= if_pc_4;
          skid_instruction <= if_instruction;
        end
        if (stall_cycles != {CNT_W{1'b1}})
          stall_cycles <= stall_cycles + CNT_W'(1);
      end else if (skid_full) begin
        id_valid       <= skid_valid;
        id_pc_4        <= skid_pc_4;
        id_instruction <= skid_instr_masked;
        skid_full      <= 1'b0;
      end else begin
        id_valid       <= if_valid;
        id_pc_4        <= if_pc_4;
        id_instruction <= in_instr_masked;
      end
    end
  end

endmodule
